vdp_host_port: RTL

Host-side write port for the video display processor: converts single-cycle register writes from the CPU bus into the VDP memory write stream (write address, write data, write enable). Provides an auto-incrementing VRAM address pointer and a hardware block-fill engine for clearing or initialising the name and tile tables. Sits between the CPU bus glue and the VDP write port, entirely in the dot_clk domain; the VDP's write_clk is tied to dot_clk.

---
 rtl/vdp_host_port.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vdp_host_port.sv
// Host-side write port for the VDP.
// Turns single-cycle CPU register writes into the VRAM write stream
// (write_addr / write_data / write_enable). Offers an auto-incrementing
// VRAM pointer and a block-fill engine that writes one byte per dot_clk.
//
// Handshake: host_wr is a one-cycle valid with no back-pressure. The port
// is "ready" whenever the FSM is in IDLE; a strobe seen while the FSM is
// filling is dropped with no side effects. The FSM leaves FILL on the edge
// that issues the last fill byte, so a strobe on the edge where busy falls
// is already taken.
module vdp_host_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = 14
) (
  input  logic                  dot_clk,
  input  logic                  reset,
  input  logic [2:0]            host_sel,
  input  logic [7:0]            host_data,
  input  logic                  host_wr,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  write_enable,
  output logic                  dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [2:0] SEL_ADDR_LO = 3'd0;
  localparam logic [2:0] SEL_ADDR_HI = 3'd1;
  localparam logic [2:0] SEL_DATA    = 3'd2;
  localparam logic [2:0] SEL_LEN_LO  = 3'd3;
  localparam logic [2:0] SEL_LEN_HI  = 3'd4;
  localparam logic [2:0] SEL_FILL    = 3'd5;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;      // fill bytes still to issue after this cycle
  logic [7:0]            r_fill_val;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_data;
  logic                  r_we;

  logic                  w_accept;
  logic                  w_data_wr;
  logic                  w_fill_start;
  logic                  w_fill_step;
  logic                  w_issue;
  logic [7:0]            w_wdata;

  // FSM state register
  always_ff @(posedge dot_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: a fill of one byte never enters FILL, longer fills leave
  // FILL on the edge that issues their last byte
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_fill_start && (r_len != LEN_WIDTH'(1))) w_next_state = S_FILL;
      S_FILL: if (r_cnt == LEN_WIDTH'(1)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: decode which action happens on this edge
  always_comb begin
    w_accept     = host_wr && (r_state == S_IDLE);
    w_data_wr    = w_accept && (host_sel == SEL_DATA);
    w_fill_start = w_accept && (host_sel == SEL_FILL) && (r_len != '0);
    w_fill_step  = (r_state == S_FILL);
    w_issue      = w_data_wr || w_fill_start || w_fill_step;
    w_wdata      = w_fill_step ? r_fill_val : host_data;
  end

  // Datapath: pointer, length, fill counter and the registered write port
  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_fill_val <= '0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
    end else begin
      r_we   <= w_issue;
      r_busy <= w_fill_start || w_fill_step;
      if (w_issue) begin
        r_addr <= r_ptr;
        r_data <= w_wdata;
        r_ptr  <= r_ptr + ADDR_WIDTH'(1);
      end else if (w_accept && (host_sel == SEL_ADDR_LO)) begin
        r_ptr[7:0] <= host_data;
      end else if (w_accept && (host_sel == SEL_ADDR_HI)) begin
        r_ptr[ADDR_WIDTH-1:8] <= host_data[ADDR_WIDTH-9:0];
      end
      if (w_accept && (host_sel == SEL_LEN_LO)) r_len[7:0] <= host_data;
      if (w_accept && (host_sel == SEL_LEN_HI)) r_len[LEN_WIDTH-1:8] <= host_data[LEN_WIDTH-9:0];
      if (w_fill_start) begin
        r_cnt      <= r_len - LEN_WIDTH'(1);
        r_fill_val <= host_data;
      end else if (w_fill_step) begin
        r_cnt <= r_cnt - LEN_WIDTH'(1);
      end
    end
  end

  assign busy         = r_busy;
  assign write_addr   = r_addr;
  assign write_data   = r_data;
  assign write_enable = r_we;
  assign dbg_state    = r_state;

endmodule
